// File: rtl/gate_truth_sequencer.sv
// Clocked stimulus/checker for a single-output combinational gate: sweeps every
// input vector, waits a settle window, samples the gate and scores it against TRUTH.
module gate_truth_sequencer #(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_out,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

    logic [1:0]    state;
    logic [7:0]    settle_cnt;
    logic          mismatch;
    logic [N_IN:0] err_next;

    // Score of the vector currently on dut_in; only consumed in SAMPLE.
    assign mismatch = (dut_out != TRUTH[dut_in]);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            settle_cnt       <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        state            <= ST_SETTLE;
                        settle_cnt       <= '0;
                        dut_in           <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        settle_cnt <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    // An abort here discards the sample; earlier partial results stay visible.
                    if (abort) begin
                        state      <= ST_IDLE;
                        settle_cnt <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_vec   <= dut_in;
                            first_fail_valid <= 1'b1;
                        end
                        if (dut_in == LAST_VEC) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            state  <= ST_SETTLE;
                            dut_in <= dut_in + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: an implication gate model (good and
// stuck variants) on the default instance, plus a NOT-gate instance with SETTLE=1.
module tb_gate_truth_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, abort, dut_out;
   logic [1:0] dut_in;
   logic       busy, done, pass;
   logic [2:0] err_count;
   logic [1:0] first_fail_vec;
   logic       first_fail_valid;

   logic       n_start, n_abort, n_dut_out;
   logic [0:0] n_dut_in;
   logic       n_busy, n_done, n_pass;
   logic [1:0] n_err_count;
   logic [0:0] n_first_fail_vec;
   logic       n_first_fail_valid;

   int gate_mode;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // gate_mode 0: a->b with a=dut_in[1], b=dut_in[0]; 1: stuck at 1; 2: stuck at 0
   assign dut_out   = (gate_mode == 1) ? 1'b1 :
                      (gate_mode == 2) ? 1'b0 : (!dut_in[1] | dut_in[0]);
   assign n_dut_out = !n_dut_in[0];

   gate_truth_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dut_out),
      .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_vec(first_fail_vec),
      .first_fail_valid(first_fail_valid)
   );

   gate_truth_sequencer #(.N_IN(1), .SETTLE(1), .TRUTH(2'b01)) u_not (
      .clk(clk), .rst(rst), .start(n_start), .abort(n_abort), .dut_out(n_dut_out),
      .dut_in(n_dut_in), .busy(n_busy), .done(n_done), .pass(n_pass),
      .err_count(n_err_count), .first_fail_vec(n_first_fail_vec),
      .first_fail_valid(n_first_fail_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a start on the next edge (edge 0), then run the given number of further edges.
   task automatic run_sweep(input int edges);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < edges; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected all zero",
                  {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid});
      end
      checks++;
      if ({n_dut_in, n_busy, n_done, n_pass, n_err_count, n_first_fail_vec, n_first_fail_valid} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_not_outputs: got %b expected all zero",
                  {n_dut_in, n_busy, n_done, n_pass, n_err_count, n_first_fail_vec, n_first_fail_valid});
      end
   endtask

   task automatic test_pass_sweep();
      logic [1:0] exp_vec;
      gate_mode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || dut_in !== 2'b00) begin
         errors++;
         $display("[TB] FAIL start_accept: busy=%b done=%b dut_in=%b expected 1 0 00", busy, done, dut_in);
      end
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp_vec = (e < 12) ? 2'(e / 3) : 2'b11;
         checks++;
         if (dut_in !== exp_vec || busy !== (e < 12) || done !== (e == 12)) begin
            errors++;
            $display("[TB] FAIL sweep_edge%0d: dut_in=%b busy=%b done=%b expected %b %b %b",
                     e, dut_in, busy, done, exp_vec, (e < 12), (e == 12));
         end
      end
      checks++;
      if (pass !== 1'b1 || err_count !== 3'd0 || first_fail_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL good_gate_result: pass=%b err=%0d ffv=%b expected 1 0 0",
                  pass, err_count, first_fail_valid);
      end
      tick();
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || dut_in !== 2'b11) begin
         errors++;
         $display("[TB] FAIL done_sticky: done=%b pass=%b dut_in=%b expected 1 1 11", done, pass, dut_in);
      end
   endtask

   task automatic test_stuck_gates();
      gate_mode = 1;
      run_sweep(12);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd1 ||
          first_fail_vec !== 2'b10 || first_fail_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stuck1: done=%b pass=%b err=%0d ffvec=%b ffv=%b expected 1 0 1 10 1",
                  done, pass, err_count, first_fail_vec, first_fail_valid);
      end
      gate_mode = 2;
      run_sweep(12);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd3 ||
          first_fail_vec !== 2'b00 || first_fail_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stuck0: done=%b pass=%b err=%0d ffvec=%b ffv=%b expected 1 0 3 00 1",
                  done, pass, err_count, first_fail_vec, first_fail_valid);
      end
      gate_mode = 0;
   endtask

   task automatic test_abort();
      gate_mode = 2;
      run_sweep(4);
      checks++;
      if (busy !== 1'b1 || dut_in !== 2'b01 || err_count !== 3'd1) begin
         errors++;
         $display("[TB] FAIL pre_abort: busy=%b dut_in=%b err=%0d expected 1 01 1", busy, dut_in, err_count);
      end
      abort = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || dut_in !== 2'b00) begin
         errors++;
         $display("[TB] FAIL abort_idle: busy=%b done=%b pass=%b dut_in=%b expected 0 0 0 00",
                  busy, done, pass, dut_in);
      end
      checks++;
      if (err_count !== 3'd1 || first_fail_valid !== 1'b1 || first_fail_vec !== 2'b00) begin
         errors++;
         $display("[TB] FAIL abort_partial: err=%0d ffv=%b ffvec=%b expected 1 1 00",
                  err_count, first_fail_valid, first_fail_vec);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err_count !== 3'd1) begin
         errors++;
         $display("[TB] FAIL abort_in_idle: busy=%b done=%b err=%0d expected 0 0 1", busy, done, err_count);
      end
      gate_mode = 0;
      run_sweep(0);
      checks++;
      if (err_count !== 3'd0 || first_fail_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_clear: err=%0d ffv=%b busy=%b expected 0 0 1",
                  err_count, first_fail_valid, busy);
      end
      for (int i = 0; i < 11; i++) tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL restart_early_done: done=%b expected 0 at edge 11", done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_sweep: done=%b pass=%b expected 1 1", done, pass);
      end
   endtask

   task automatic test_start_held();
      gate_mode = 0;
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (dut_in !== 2'b01 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_no_restart: dut_in=%b busy=%b expected 01 1", dut_in, busy);
      end
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_done: done=%b busy=%b pass=%b expected 1 0 1", done, busy, pass);
      end
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || dut_in !== 2'b00) begin
         errors++;
         $display("[TB] FAIL held_restart: done=%b busy=%b dut_in=%b expected 0 1 00", done, busy, dut_in);
      end
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_second_sweep: done=%b pass=%b expected 1 1", done, pass);
      end
   endtask

   task automatic test_reset_mid();
      gate_mode = 2;
      run_sweep(6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got %b expected all zero",
                  {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid});
      end
      start = 1'b1;
      abort = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 2'b00) begin
         errors++;
         $display("[TB] FAIL start_abort_idle: busy=%b done=%b dut_in=%b expected 0 0 00", busy, done, dut_in);
      end
      start = 1'b0;
      abort = 1'b0;
      gate_mode = 0;
      run_sweep(12);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || dut_in !== 2'b11) begin
         errors++;
         $display("[TB] FAIL start_abort_done: done=%b busy=%b pass=%b dut_in=%b expected 1 0 1 11",
                  done, busy, pass, dut_in);
      end
   endtask

   task automatic test_not_gate();
      n_start = 1'b1;
      tick();
      n_start = 1'b0;
      tick();
      tick();
      checks++;
      if (n_dut_in !== 1'b1 || n_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL not_vec1: dut_in=%b busy=%b expected 1 1", n_dut_in, n_busy);
      end
      tick();
      checks++;
      if (n_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL not_early: done=%b expected 0 at edge 3", n_done);
      end
      tick();
      checks++;
      if (n_done !== 1'b1 || n_pass !== 1'b1 || n_err_count !== 2'd0 || n_first_fail_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL not_done: done=%b pass=%b err=%0d ffv=%b expected 1 1 0 0",
                  n_done, n_pass, n_err_count, n_first_fail_valid);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      n_start   = 1'b0;
      n_abort   = 1'b0;
      gate_mode = 0;
      test_reset();
      test_pass_sweep();
      test_stuck_gates();
      test_abort();
      test_start_held();
      test_reset_mid();
      test_not_gate();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
